// File: rtl/if_id_fetch_queue_pkg.sv
// Shared sizing constants for the fetch-to-decode instruction queue.
package if_id_fetch_queue_pkg;
  localparam int ADDRESS_LEN       = 32;
  localparam int INSTRUCTION_LEN   = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;
endpackage

// File: rtl/if_id_fetch_queue_fq_ptr_counter.sv
// Wrapping pointer with synchronous reset, clear (flush) and increment.
module fq_ptr_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Power-of-two depth: natural overflow of W bits is the wrap to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_inc)     r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/if_id_fetch_queue.sv
// In-order {PC, instruction} buffer between fetch and decode; flush empties it.
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = FETCH_QUEUE_DEPTH,
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int INSTR_W = INSTRUCTION_LEN,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   count,
  output logic               freeze_if
);
  // Handshake: a transfer happens on an edge where valid & ready are both high
  // and flush is low; ready depends only on registered occupancy, never on the
  // other side's valid/ready, so there is no combinational in->out path.
  logic [ADDR_W+INSTR_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]          r_count;
  logic [PTR_W-1:0]          w_head;
  logic [PTR_W-1:0]          w_tail;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full & ~flush & ~rst;
  assign w_pop   = ~w_empty & out_ready & ~flush & ~rst;

  fq_ptr_counter #(.W(PTR_W)) u_head (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (flush),
    .i_inc (w_pop),
    .o_cnt (w_head)
  );

  fq_ptr_counter #(.W(PTR_W)) u_tail (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (flush),
    .i_inc (w_push),
    .o_cnt (w_tail)
  );

  // Storage is deliberately not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_tail] <= {in_pc, in_instr};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) r_count <= '0;
    else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = ~w_full;
  assign freeze_if = w_full;
  assign out_valid = ~w_empty;
  assign count     = r_count;
  assign out_pc    = out_valid ? r_mem[w_head][ADDR_W+INSTR_W-1:INSTR_W] : '0;
  assign out_instr = out_valid ? r_mem[w_head][INSTR_W-1:0] : '0;
endmodule
